// File: rtl/fdiv_prog.sv
//==============================================================================
// Module   : fdiv_prog
// Brief    : Programmable clock divider with glitch-free divisor updates.
//            Optional macro FDIV_DUTY_EN adds duty_in for a programmable low phase.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fdiv_prog #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned P0    = 512000,
    parameter int unsigned P1    = 1024000,
    parameter int unsigned P2    = 2048000,
    parameter int unsigned P3    = 4096000
) (
    input  logic             fin,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic             div_ld,
    input  logic [WIDTH-1:0] div_in,
`ifdef FDIV_DUTY_EN
    input  logic [WIDTH-1:0] duty_in,
`endif
    output logic             fout,
    output logic             tick,
    output logic             upd_ack
);

    localparam logic [WIDTH-1:0] c_p0   = WIDTH'(P0);
    localparam logic [WIDTH-1:0] c_p1   = WIDTH'(P1);
    localparam logic [WIDTH-1:0] c_p2   = WIDTH'(P2);
    localparam logic [WIDTH-1:0] c_p3   = WIDTH'(P3);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_two  = WIDTH'(2);

    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_v;
    logic [1:0]       r_sel_q;
    logic [WIDTH-1:0] r_count;
    logic             r_fout_q;
    logic             r_tick;
    logic             r_upd_ack;

    logic [WIDTH-1:0] w_preset;
    logic [WIDTH-1:0] w_half;
    logic             w_sel_chg;
    logic             w_bypass;
    logic             w_at_end;
    logic             w_boundary;
    logic             w_apply;

`ifdef FDIV_DUTY_EN
    logic [WIDTH-1:0] r_pend_duty;
    logic [WIDTH-1:0] r_cur_duty;
`endif

    always_comb begin
        case (sel)
            2'd0:    w_preset = c_p0;
            2'd1:    w_preset = c_p1;
            2'd2:    w_preset = c_p2;
            default: w_preset = c_p3;
        endcase
    end

    assign w_sel_chg = (sel != r_sel_q);
    assign w_bypass  = (r_cur_div < c_two);
    assign w_at_end  = (r_count == r_cur_div);

    // In bypass every cycle is a full output period, so it is also a boundary;
    // this keeps D=0 from locking out later divisor updates.
    assign w_boundary = ~en | w_at_end | w_bypass;
    assign w_apply    = w_boundary & r_pend_v;

`ifdef FDIV_DUTY_EN
    always_comb begin
        if ((r_cur_duty != '0) && (r_cur_duty < r_cur_div)) begin
            w_half = r_cur_duty;
        end else begin
            w_half = r_cur_div >> 1;
        end
    end
`else
    assign w_half = r_cur_div >> 1;
`endif

    // Divisor capture and hand-over; the value pending at the boundary is the
    // one applied, while a same-cycle capture becomes the next pending value.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_div  <= c_p0;
            r_pend_div <= '0;
            r_pend_v   <= 1'b0;
            r_sel_q    <= 2'd0;
            r_upd_ack  <= 1'b0;
        end else begin
            r_sel_q   <= sel;
            r_upd_ack <= w_apply;
            if (w_apply) begin
                r_cur_div <= r_pend_div;
            end
            if (div_ld) begin
                r_pend_div <= div_in;
                r_pend_v   <= 1'b1;
            end else if (w_sel_chg) begin
                r_pend_div <= w_preset;
                r_pend_v   <= 1'b1;
            end else if (w_apply) begin
                r_pend_v   <= 1'b0;
            end
        end
    end

`ifdef FDIV_DUTY_EN
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_duty <= '0;
            r_cur_duty  <= '0;
        end else begin
            if (w_apply) begin
                r_cur_duty <= r_pend_duty;
            end
            if (div_ld) begin
                r_pend_duty <= duty_in;
            end else if (w_sel_chg) begin
                r_pend_duty <= '0;
            end
        end
    end
`endif

    // Period counter and registered outputs; both lag count by one cycle.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= c_one;
            r_fout_q <= 1'b0;
            r_tick   <= 1'b0;
        end else if (!en) begin
            r_count  <= c_one;
            r_fout_q <= 1'b0;
            r_tick   <= 1'b0;
        end else if (w_bypass) begin
            r_count  <= c_one;
            r_fout_q <= (r_count > w_half);
            r_tick   <= 1'b1;
        end else begin
            r_count  <= w_at_end ? c_one : (r_count + c_one);
            r_fout_q <= (r_count > w_half);
            r_tick   <= w_at_end;
        end
    end

    // D=1 passes the input clock straight through, gated only by en.
    always_comb begin
        if (r_cur_div == c_one) begin
            fout = fin & en;
        end else if (r_cur_div == '0) begin
            fout = 1'b0;
        end else begin
            fout = r_fout_q;
        end
    end

    assign tick    = r_tick;
    assign upd_ack = r_upd_ack;

endmodule

`default_nettype wire

// File: tb/tb_fdiv_prog.sv
// Scoreboard bench for fdiv_prog: driver pushes expected outputs from a
// period-position reference model, monitor pops and compares after each edge.
`default_nettype none

module tb_fdiv_prog;

    localparam int WIDTH = 8;
    localparam int unsigned PRE [4] = '{2, 4, 8, 16};
`ifdef FDIV_DUTY_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    logic             fin = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       sel = 2'd0;
    logic             div_ld = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic [WIDTH-1:0] duty_in = '0;
    logic             fout;
    logic             tick;
    logic             upd_ack;

    int checks = 0;
    int failures = 0;
    logic [2:0] sb_q[$];

    // Reference model: period length, position within the period (0-based),
    // low-phase length and a single pending update slot.
    int unsigned m_d = PRE[0];
    int unsigned m_duty = 0;
    int unsigned m_pos = 0;
    int unsigned m_pend = 0;
    int unsigned m_pduty = 0;
    bit          m_pv = 1'b0;
    bit [1:0]    m_selq = 2'd0;

    always #5 fin = ~fin;

    fdiv_prog #(
        .WIDTH(WIDTH),
        .P0(PRE[0]),
        .P1(PRE[1]),
        .P2(PRE[2]),
        .P3(PRE[3])
    ) dut (
        .fin(fin),
        .rst_n(rst_n),
        .en(en),
        .sel(sel),
        .div_ld(div_ld),
        .div_in(div_in),
`ifdef FDIV_DUTY_EN
        .duty_in(duty_in),
`endif
        .fout(fout),
        .tick(tick),
        .upd_ack(upd_ack)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model across one rising edge with the inputs now applied.
    task automatic model_step(output logic [2:0] exp);
        int unsigned low_len;
        bit bypass, last_pos, bnd, lvl, tk, ack;
        if (!rst_n) begin
            m_d = PRE[0]; m_duty = 0; m_pv = 1'b0; m_selq = 2'd0; m_pos = 0;
            exp = 3'b000;
            return;
        end
        low_len  = (DUTY_ON && m_duty > 0 && m_duty < m_d) ? m_duty : m_d / 2;
        bypass   = (m_d < 2);
        last_pos = !bypass && (m_pos == m_d - 1);
        bnd      = !en || bypass || last_pos;
        tk       = en && (bypass || last_pos);
        lvl      = en && (m_pos >= low_len);
        ack      = bnd && m_pv;
        m_pos    = bnd ? 0 : m_pos + 1;
        if (ack) begin
            m_d = m_pend; m_duty = m_pduty; m_pv = 1'b0;
        end
        if (div_ld) begin
            m_pend = int'(div_in); m_pduty = int'(duty_in); m_pv = 1'b1;
        end else if (sel != m_selq) begin
            m_pend = PRE[sel]; m_pduty = 0; m_pv = 1'b1;
        end
        m_selq = sel;
        exp = {(m_d == 1) ? en : ((m_d == 0) ? 1'b0 : lvl), tk, ack};
    endtask

    task automatic cyc(input bit r, input bit e, input bit [1:0] s, input bit l,
                       input int unsigned d, input int unsigned dt);
        logic [2:0] ex;
        bit prev_r;
        prev_r  = rst_n;
        rst_n   = r;
        en      = e;
        sel     = s;
        div_ld  = l;
        div_in  = WIDTH'(d);
        duty_in = WIDTH'(dt);
        if (prev_r && !r) begin
            #1;
            check("async_rst_fout", fout, 1'b0);
            check("async_rst_tick", tick, 1'b0);
            check("async_rst_ack", upd_ack, 1'b0);
        end
        model_step(ex);
        sb_q.push_back(ex);
        @(negedge fin);
    endtask

    task automatic run(input int n, input bit e, input bit [1:0] s);
        for (int k = 0; k < n; k++) cyc(1'b1, e, s, 1'b0, 0, 0);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge fin);
            #1;
            if (sb_q.size() == 0) begin
                check("sb_expect_present", 1'b0, 1'b1);
            end else begin
                e = sb_q.pop_front();
                check("fout", fout, e[2]);
                check("tick", tick, e[1]);
                check("upd_ack", upd_ack, e[0]);
            end
        end
    end

    initial begin
        bit [1:0] s_cur;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        run(20, 1'b1, 2'd1);
        run(41, 1'b1, 2'd3);
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 5, 0);
        run(30, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 1, 0);
        run(8, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 0, 0);
        run(6, 1'b1, 2'd2);
        cyc(1'b1, 1'b0, 2'd2, 1'b1, 4, 0);
        cyc(1'b1, 1'b0, 2'd2, 1'b0, 0, 0);
        run(13, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 7, 0);
        run(1, 1'b1, 2'd2);
        cyc(1'b1, 1'b0, 2'd2, 1'b0, 0, 0);
        run(30, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 9, 0);
        run(2, 1'b1, 2'd2);
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 0, 0);
        run(12, 1'b1, 2'd0);
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 10, 3);
        run(30, 1'b1, 2'd0);

        s_cur = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            bit r, e, l;
            r = ($urandom_range(199) != 0);
            e = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) s_cur = 2'($urandom_range(3));
            l = ($urandom_range(24) == 0);
            cyc(r, e, s_cur, l, $urandom_range(20), $urandom_range(12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fdiv_prog.md
# fdiv_prog

Programmable clock-enable/frequency divider, successor to the fixed four-preset divider. Divides `fin` by a runtime divisor selected from four parameterised presets or loaded directly. The divisor can be changed without glitches: a new value takes effect only at a period boundary. The block emits a square output plus a one-cycle period tick, and sits between the board oscillator and slow consumers (LED scan, buzzer, counters) in the experiment designs.

## Interface
- `WIDTH`, 32, counter/divisor width
- `P0`, 512000, preset divisor for `sel`=0
- `P1`, 1024000, preset divisor for `sel`=1
- `P2`, 2048000, preset divisor for `sel`=2
- `P3`, 4096000, preset divisor for `sel`=3
- `fin`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable
- `sel`  in  2  preset select
- `div_ld`  in  1  one-cycle strobe: capture `div_in` (and `duty_in`) as the pending divisor
- `div_in`  in  WIDTH  direct divisor value
- `duty_in`  in  WIDTH  low-phase length; present only with `FDIV_DUTY_EN`
- `fout`  out  1  divided clock
- `tick`  out  1  one-cycle pulse per output period
- `upd_ack`  out  1  one-cycle pulse when the pending divisor becomes active

## Operation
- Registers:
  - `cur_div`: active divisor, D.
  - `pend_div` and `pend_v`: pending update and its valid flag.
  - `sel_q`: last `sel` sampled.
  - `count`: runs 1..D.
  - `fout_q`, `tick`, `upd_ack`.
- Reset values:
  - `cur_div`=P0, `sel_q`=0, `pend_v`=0, `count`=1.
  - `fout_q`=0, `tick`=0, `upd_ack`=0.
  - Because `sel_q` resets to 0, any `sel`≠0 after reset is treated as a change.
- Update capture, per cycle:
  - `div_ld`=1: `pend_div`<=`div_in` and `pend_v`<=1.
  - Otherwise, if `sel`≠`sel_q`: `pend_div`<=P[`sel`] and `pend_v`<=1.
  - `sel_q`<=`sel` every cycle.
  - If `div_ld` and a `sel` change coincide, `div_ld` wins and the `sel` change is discarded.
  - A later capture before the boundary overwrites the earlier one; the last value wins.
- Counting with `en`=1 and D≥2:
  - When `count`==D: `count`<=1.
  - Otherwise: `count`<=`count`+1.
- Period boundary is the cycle where `count`==D, or any cycle with `en`=0. At the boundary, if `pend_v`=1: `cur_div`<=`pend_div`, `pend_v`<=0, `upd_ack`<=1.
- Output:
  - Threshold H = D>>1.
  - `fout_q`<=(`count`>H).
  - Result: low for H cycles and high for D−H cycles; for odd D the extra cycle is in the high phase.
- Tick: `tick`<=(`count`==D)&`en`.
- Bypass when D<2:
  - D=1: `fout`=`fin`&`en` (combinational pass-through, intentional).
  - D=0: `fout`=0.
  - In both cases `tick`<=`en` every cycle and `count` is held at 1.
  - Otherwise `fout`=`fout_q`.
- `en`=0:
  - `count`<=1, `fout_q`<=0, `tick`<=0.
  - A pending update is applied on the next edge.
- Arithmetic: all compares are unsigned WIDTH-bit. `count` never exceeds D, so there is no wrap. A divisor change cannot produce a partial period.

## Timing
- All state updates on posedge `fin`. `rst_n` low clears all registers immediately, including mid-period and with an update pending (the pending update is dropped).
- Latency:
  - `fout_q` and `tick` reflect the `count` value of the previous cycle.
  - The first `tick` occurs D cycles after `en` rises.
- Divisor update latency: from the capture cycle to the end of the current period (at most D cycles). `upd_ack` is high in the first cycle of the new period.
- A `div_ld` in the boundary cycle itself lands in `pend_div` and is applied at the next boundary. The currently pending value is the one applied now.

## Configuration
- `FDIV_DUTY_EN`, defined:
  - `duty_in` port exists and `pend_duty` is captured with `div_ld`.
  - H = `cur_duty` if 0<`cur_duty`<D, else D>>1.
  - Preset loads set `cur_duty`=0, i.e. 50% duty.
- `FDIV_DUTY_EN`, undefined: no `duty_in` port; H = D>>1 always.

## Test plan
- P0..P3=2,4,8,16; reset released, `en`=1, `sel`=1 -> `upd_ack` after first P0 period. Then `fout` low 2 / high 2, `tick` every 4 cycles.
- `sel` 1->3 at mid-period (`count`=2) -> current 4-cycle period completes. Then `upd_ack` fires and the period becomes 16 (8 low / 8 high).
- `div_ld` with `div_in`=5 in the same cycle as `sel` change to 2 -> D becomes 5 at the boundary (low 2, high 3); the `sel` change is ignored.
- `div_ld` with 1, then 0 -> D=1: `fout` follows `fin` and `tick` is constant 1. D=0: `fout`=0.
- `en` dropped mid-period with a pending 7 -> next edge: `count`=1, `fout`=0, `upd_ack`=1. After `en` returns, the period is 7.
- `rst_n` pulsed low mid-period with update pending -> all outputs 0 asynchronously, D=P0, no `upd_ack`; with `FDIV_DUTY_EN`, `div_ld` 10/`duty_in` 3 gives low 3 / high 7.
